seq_det_ctrl: RTL
=================

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter RST_PAT, default 4'b1011, SHALL be the pattern register value after reset.
REQ-002 Parameter RST_LEN, default 3'd4, SHALL be the pattern-length register value after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low (rst=0 resets).
REQ-005 cfg_we  input  1  SHALL be the config write strobe.
REQ-006 cfg_pattern  input  4  SHALL be the pattern to load; bit 0 is the most recently received bit.
REQ-007 cfg_len  input  3  SHALL be the pattern length to load, valid range 1..4.
REQ-008 cfg_overlap  input  1  SHALL select overlap mode when 1 and non-overlap mode when 0.
REQ-009 start  input  1  SHALL be a one-cycle request to begin a detection window.
REQ-010 win_len  input  8  SHALL be the window length in bits, captured on start; the value 0 means 256.
REQ-011 din  input  1  SHALL be the serial data bit.
REQ-012 busy  output  1  SHALL be high while a window is in progress.
REQ-013 match  output  1  SHALL be a one-cycle, registered pulse per detected match.
REQ-014 done  output  1  SHALL be a one-cycle, registered pulse at window end.
REQ-015 match_cnt  output  8  SHALL be the number of matches in the current or last window.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-017 Configuration:
- cfg_we in IDLE or DONE SHALL load pattern, length and overlap at the next edge.
- cfg_we in RUN SHALL be ignored.
REQ-018 A loaded cfg_len of 0 or greater than 4 SHALL be stored as 4.
REQ-019 Starting a window:
- start in IDLE or DONE SHALL capture win_len, clear match_cnt, the shift register and the fill count, and move to RUN at that edge.
- start in RUN SHALL be ignored.
REQ-020 Sampling in RUN:
- Each rising edge SHALL shift din into a 4-bit shift register (new bit to bit 0).
- Each such edge SHALL increment the fill count (saturating at 4) and the bit count.
REQ-021 Match condition: after the shift, fill count >= len AND shift[len-1:0] == pattern[len-1:0].
REQ-022 Match response:
- match SHALL be 1 in the cycle following the sampling edge.
- match_cnt SHALL increment at that same edge.
REQ-023 match_cnt SHALL saturate at 255.
REQ-024 Non-overlap mode: a match SHALL reset the fill count to 0, so a new match needs len fresh bits.
REQ-025 Overlap mode: a match SHALL leave the fill count unchanged.
REQ-026 Window end:
- The edge sampling bit number win_len (256 if 0) SHALL move the FSM to DONE.
- In the cycle after that edge, busy SHALL be 0 and done SHALL be 1.
- match for the final bit SHALL coincide with done.
REQ-027 DONE SHALL last exactly one cycle, then go to IDLE unless start is high, in which case it goes to RUN.
REQ-028 match_cnt SHALL hold its value in DONE and IDLE until the next start.
REQ-029 din SHALL be ignored outside RUN.
REQ-030 Busy timing: busy SHALL rise in the cycle after the start edge and SHALL stay high for exactly win_len cycles (256 if 0).

Reset
REQ-031 While rst=0, the block SHALL immediately set the following, regardless of clk:
- FSM = IDLE
- busy = 0, match = 0, done = 0, match_cnt = 0
- shift register, fill count and bit count = 0
- pattern = RST_PAT, len = RST_LEN, overlap = 1
REQ-032 A reset during RUN SHALL abort the window with no done pulse.
REQ-033 After rst returns to 1, the block SHALL need a new start to begin a window.

Verification
REQ-034 Overlap window: defaults, win_len=7, din=1,0,1,1,0,1,1 -> match after bits 4 and 7; match_cnt=2; done coincident with the 2nd match.
REQ-035 Non-overlap window: cfg_overlap=0, same stream -> single match after bit 4; match_cnt=1 at done.
REQ-036 Short pattern: cfg_len=2, pattern=2'b10 (previous bit 1, current bit 0), overlap=1, win_len=6, din=1,0,1,0,1,0 -> matches after bits 2, 4 and 6; match_cnt=3.
REQ-037 win_len=0 saturation: pattern=1, len=1, din held at 1 -> busy high for 256 cycles; match_cnt saturates at 255; one done pulse.
REQ-038 Ignored requests: start and cfg_we pulsed mid-RUN -> no restart; config unchanged; match_cnt continues counting.
REQ-039 Reset mid-window: rst=0 at bit 3 of 7 -> busy, match_cnt and match go to 0 immediately; no done; pattern returns to 4'b1011.

Source files
------------

// File: rtl/seq_det_ctrl_if.sv
// rtl/seq_det_ctrl_if.sv - configuration, window control and result signals of seq_det_ctrl
interface seq_det_ctrl_if;
    logic       cfg_we;
    logic [3:0] cfg_pattern;
    logic [2:0] cfg_len;
    logic       cfg_overlap;
    logic       start;
    logic [7:0] win_len;
    logic       din;
    logic       busy;
    logic       match;
    logic       done;
    logic [7:0] match_cnt;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, start, win_len, din,
        input  busy, match, done, match_cnt
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, start, win_len, din,
        output busy, match, done, match_cnt
    );
endinterface

// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - windowed serial pattern detector with overlap/non-overlap counting
module seq_det_ctrl #(
    parameter logic [3:0] RST_PAT = 4'b1011,
    parameter logic [2:0] RST_LEN = 3'd4
) (
    input  logic          clk,
    input  logic          rst,
    seq_det_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] pattern_q, pattern_d;
    logic [2:0] len_q, len_d;
    logic       overlap_q, overlap_d;
    logic [3:0] shift_q, shift_d;
    logic [2:0] fill_q, fill_d;
    logic [8:0] bit_cnt_q, bit_cnt_d;
    logic [8:0] win_q, win_d;
    logic [7:0] match_cnt_q, match_cnt_d;
    logic       match_q, match_d;
    logic       done_q, done_d;

    logic [3:0] shift_next;
    logic [3:0] len_mask;
    logic [2:0] fill_inc;
    logic [2:0] cfg_len_fix;
    logic [8:0] bit_cnt_inc;
    logic       hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pattern_q   <= RST_PAT;
            len_q       <= RST_LEN;
            overlap_q   <= 1'b1;
            shift_q     <= 4'd0;
            fill_q      <= 3'd0;
            bit_cnt_q   <= 9'd0;
            win_q       <= 9'd0;
            match_cnt_q <= 8'd0;
            match_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            len_q       <= len_d;
            overlap_q   <= overlap_d;
            shift_q     <= shift_d;
            fill_q      <= fill_d;
            bit_cnt_q   <= bit_cnt_d;
            win_q       <= win_d;
            match_cnt_q <= match_cnt_d;
            match_q     <= match_d;
            done_q      <= done_d;
        end
    end

    // Compare only the low len bits of the post-shift history against the pattern.
    always_comb begin
        shift_next  = {shift_q[2:0], bus.din};
        fill_inc    = (fill_q >= 3'd4) ? 3'd4 : fill_q + 3'd1;
        bit_cnt_inc = bit_cnt_q + 9'd1;
        case (len_q)
            3'd1:    len_mask = 4'b0001;
            3'd2:    len_mask = 4'b0011;
            3'd3:    len_mask = 4'b0111;
            default: len_mask = 4'b1111;
        endcase
        hit = (fill_inc >= len_q) && ((shift_next & len_mask) == (pattern_q & len_mask));
        cfg_len_fix = ((bus.cfg_len == 3'd0) || (bus.cfg_len > 3'd4)) ? 3'd4 : bus.cfg_len;
    end

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        len_d       = len_q;
        overlap_d   = overlap_q;
        shift_d     = shift_q;
        fill_d      = fill_q;
        bit_cnt_d   = bit_cnt_q;
        win_d       = win_q;
        match_cnt_d = match_cnt_q;
        match_d     = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.cfg_we) begin
                    pattern_d = bus.cfg_pattern;
                    len_d     = cfg_len_fix;
                    overlap_d = bus.cfg_overlap;
                end
                if (bus.start) begin
                    win_d       = (bus.win_len == 8'd0) ? 9'd256 : {1'b0, bus.win_len};
                    match_cnt_d = 8'd0;
                    shift_d     = 4'd0;
                    fill_d      = 3'd0;
                    bit_cnt_d   = 9'd0;
                    state_d     = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                shift_d   = shift_next;
                bit_cnt_d = bit_cnt_inc;
                fill_d    = fill_inc;
                if (hit) begin
                    match_d = 1'b1;
                    if (match_cnt_q != 8'hFF) begin
                        match_cnt_d = match_cnt_q + 8'd1;
                    end
                    // Non-overlap restarts the fill so the next match needs len fresh bits.
                    if (!overlap_q) begin
                        fill_d = 3'd0;
                    end
                end
                if (bit_cnt_inc == win_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.match     = match_q;
    assign bus.done      = done_q;
    assign bus.match_cnt = match_cnt_q;

endmodule
